seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed digits (1..16).
REQ-002 SHALL have parameter DIV, default 50000, clock cycles per digit slot (>=2).
REQ-003 SHALL have parameter GUARD, default 16, cycles at slot start with anodes off (0..DIV-1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, 1 = seg/an active-low, 0 = active-high.
REQ-005 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port load  input  1  one-cycle strobe capturing value/dp/blank/lz_en.
REQ-008 SHALL have port value  input  4*DIGITS  hex nibbles, nibble i drives digit i.
REQ-009 SHALL have port dp  input  DIGITS  decimal point enable per digit.
REQ-010 SHALL have port blank  input  DIGITS  force digit i dark.
REQ-011 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-012 SHALL have port seg  output  8  segment bus {dp,g,f,e,d,c,b,a}.
REQ-013 SHALL have port an  output  DIGITS  one-hot digit enable.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-015 SHALL decode nibbles via internal 16-entry table, active-low form: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (hex, bit7=dp off).
REQ-016 SHALL clear bit7 of the active-low code when dp[i]=1; ACTIVE_LOW=0 SHALL bitwise-invert seg and an.
REQ-017 SHALL run prescaler 0..DIV-1 wrapping to 0; at DIV-1 digit index advances 0..DIGITS-1, wrapping to 0.
REQ-018 SHALL assert frame_done for exactly the cycle the index wraps DIGITS-1 -> 0.
REQ-019 SHALL double-buffer: load writes shadow registers and sets pending; display registers update only at the index wrap cycle if pending, then pending clears.
REQ-020 SHALL, when load coincides with the wrap cycle, copy the new input directly to display registers and leave pending clear.
REQ-021 SHALL let a later load overwrite an earlier pending one (last load before wrap wins).
REQ-022 SHALL drive an all-off while prescaler < GUARD, else the bit for the current index on.
REQ-023 SHALL drive seg all-off when digit is blanked, in guard period, or leading-zero suppressed.
REQ-024 SHALL, with lz_en=1, suppress digit i>0 when nibbles i..DIGITS-1 are all zero; digit 0 always shown; dp of a suppressed digit also dark.
REQ-025 SHALL register seg and an; they reflect index/prescaler state with exactly 1 cycle latency.

Reset
REQ-026 SHALL on rst_n=0 at a clock edge set prescaler=0, index=0, pending=0, shadow and display registers=0, frame_done=0.
REQ-027 SHALL during and on the cycle after reset drive seg and an to all-off (8'hFF / all-ones when ACTIVE_LOW=1).
REQ-028 SHALL discard a pending load if reset asserts before the wrap.

Verification (DIGITS=4, DIV=4, GUARD=1, ACTIVE_LOW=1)
REQ-029 SHALL cover: reset, load value=16'h1234 dp=0 -> after first wrap an cycles 1110,1101,1011,0111 with seg 99,B0,A4,F9 (digit 0 = nibble 4), each 3 cycles on, 1 guard cycle an=1111.
REQ-030 SHALL cover: free run -> frame_done pulses once every 16 cycles, width 1.
REQ-031 SHALL cover: value=16'h0005 lz_en=1 -> digits 3..1 seg=FF, digit 0 seg=92; lz_en=0 -> digits 3..1 seg=C0.
REQ-032 SHALL cover: load 16'hAAAA mid-frame then 16'hBBBB before wrap -> current frame unchanged, next frame shows 83 on all digits.
REQ-033 SHALL cover: load 16'hCDEF on wrap cycle -> same frame shows 8E,86,A1,C6; dp=4'b0001 -> digit 0 seg=0E.
REQ-034 SHALL cover: rst_n low mid-frame with pending load -> an=1111, seg=FF, after release display shows 0 (C0) on all digits.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver.
// Steps through DIGITS digit slots of DIV clocks each, holding the anodes off
// for the first GUARD clocks of every slot to avoid ghosting. New content is
// double-buffered and only reaches the display at a frame boundary, so a
// frame is never drawn from two different values.
module seg7_scan_driver #(
    parameter int DIGITS     = 8,
    parameter int DIV        = 50000,
    parameter int GUARD      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blank,
    input  logic                lz_en,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam bit POL_LOW = (ACTIVE_LOW != 0);

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic                pending;
    logic [4*DIGITS-1:0] sh_value,  disp_value;
    logic [DIGITS-1:0]   sh_dp,     disp_dp;
    logic [DIGITS-1:0]   sh_blank,  disp_blank;
    logic                sh_lz,     disp_lz;

    logic                slot_end;
    logic                wrap;
    logic [3:0]          nib;
    logic                upper_nonzero;
    logic                suppress;
    logic                in_guard;
    logic [7:0]          seg_low;
    logic [DIGITS-1:0]   an_low;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one hex nibble, dp off.
    function automatic logic [7:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    return 8'hC0;
            4'h1:    return 8'hF9;
            4'h2:    return 8'hA4;
            4'h3:    return 8'hB0;
            4'h4:    return 8'h99;
            4'h5:    return 8'h92;
            4'h6:    return 8'h82;
            4'h7:    return 8'hF8;
            4'h8:    return 8'h80;
            4'h9:    return 8'h90;
            4'hA:    return 8'h88;
            4'hB:    return 8'h83;
            4'hC:    return 8'hC6;
            4'hD:    return 8'hA1;
            4'hE:    return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    assign slot_end = (presc == PRESC_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    // Pattern for the current slot, computed in active-low form.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        upper_nonzero = 1'b0;
        nib           = disp_value[{idx, 2'b00} +: 4];
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx) && disp_value[4*j +: 4] != 4'h0) upper_nonzero = 1'b1;
        end
        // A leading zero is this nibble and everything above it being zero; digit 0 always shows.
        suppress = disp_lz && (idx != '0) && !upper_nonzero;
        in_guard = (int'(presc) < GUARD);
        if (in_guard || disp_blank[idx] || suppress) begin
            seg_low = 8'hFF;
        end else begin
            seg_low = decode(nib) & ~{disp_dp[idx], 7'b0};
        end
        an_low = in_guard ? '1 : ~(DIGITS'(1) << idx);
    end

    // Scan counters plus shadow/display double buffer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            // NOTE: the buffers are reset too, so a stale pending load cannot survive a reset.
            presc      <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_lz      <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            disp_lz    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (slot_end) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end

            if (wrap) begin
                // A load landing on the boundary bypasses the shadow and wins outright.
                if (load) begin
                    disp_value <= value;
                    disp_dp    <= dp;
                    disp_blank <= blank;
                    disp_lz    <= lz_en;
                end else if (pending) begin
                    disp_value <= sh_value;
                    disp_dp    <= sh_dp;
                    disp_blank <= sh_blank;
                    disp_lz    <= sh_lz;
                end
                pending <= 1'b0;
            end else if (load) begin
                sh_value <= value;
                sh_dp    <= dp;
                sh_blank <= blank;
                sh_lz    <= lz_en;
                pending  <= 1'b1;
            end
        end
    end

    // Registered pin drive with output polarity applied; dark during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= POL_LOW ? 8'hFF : 8'h00;
            an  <= POL_LOW ? '1 : '0;
        end else begin
            seg <= POL_LOW ? seg_low : ~seg_low;
            an  <= POL_LOW ? an_low : ~an_low;
        end
    end

endmodule
